// File: rtl/dram_port_arb.sv
// dram_port_arb - N-port round-robin arbiter in front of the sdram_ctl
// command interface.
//
// Each requester holds port_req until its one-cycle port_done pulse. The
// winner's command is latched in IDLE, strobed for one cycle in ISSUE, and
// held stable through WAIT until the controller pulses dram_data_ready. If
// that pulse does not arrive within TIMEOUT_CYCLES cycles, the transaction
// ends with port_err set. Read data is captured into rdata for single reads
// and into burst_buf for bursts. Both stay valid until the next grant.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   port_req/_write/_burst/_addr/_wdata   per-port request fields (flattened)
//   port_done, port_err completion pulse (one-hot) and timeout flag
//   rdata, burst_buf    captured read data
//   grant_id, busy      port being served, arbiter not idle
//   dram_*              sdram_ctl command/response interface
//
// Optional feature macro: DRAM_PORT_ARB_PRIO0_EN
//   Defined: port 0 wins whenever it requests. The other ports round-robin
//   among themselves, and a port 0 grant leaves rr_ptr unchanged.
//   Undefined: pure round robin across all ports.
module dram_port_arb #(
  parameter int unsigned         N_PORTS        = 3,
  parameter int unsigned         ADDR_W         = 25,
  parameter int unsigned         DATA_W         = 16,
  parameter int unsigned         BURST_LEN      = 32,
  parameter logic [N_PORTS-1:0]  BURST_PORTS    = 3'b100,
  parameter int unsigned         TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_PORTS-1:0]            port_req,
  input  logic [N_PORTS-1:0]            port_write,
  input  logic [N_PORTS-1:0]            port_burst,
  input  logic [N_PORTS*ADDR_W-1:0]     port_addr,
  input  logic [N_PORTS*DATA_W-1:0]     port_wdata,
  output logic [N_PORTS-1:0]            port_done,
  output logic                          port_err,
  output logic [DATA_W-1:0]             rdata,
  output logic [BURST_LEN*DATA_W-1:0]   burst_buf,
  output logic [$clog2(N_PORTS)-1:0]    grant_id,
  output logic                          busy,
  input  logic                          dram_mem_ready,
  input  logic                          dram_data_ready,
  input  logic [DATA_W-1:0]             dram_read_data,
  input  logic [BURST_LEN*DATA_W-1:0]   dram_burst_data,
  output logic                          dram_refresh_data,
  output logic                          dram_write_en,
  output logic                          dram_burst_en,
  output logic [ADDR_W-1:0]             dram_addr,
  output logic [DATA_W-1:0]             dram_data_in
);

  localparam int unsigned GW = $clog2(N_PORTS);
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                        state_q, state_d;
  logic [GW-1:0]                 grant_q, grant_d;
  logic [GW-1:0]                 rr_q, rr_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [DATA_W-1:0]             wdata_q, wdata_d;
  logic                          we_q, we_d;
  logic                          burst_q, burst_d;
  logic                          err_q, err_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [DATA_W-1:0]             rdata_q, rdata_d;
  logic [BURST_LEN*DATA_W-1:0]   bbuf_q, bbuf_d;

  // Winner search: first requester at or above rr_q, wrapping modulo N_PORTS.
  logic [N_PORTS-1:0] scan_req;
  logic               found;
  logic [GW-1:0]      win;
  int unsigned        idx;
  int unsigned        win_i;

  always_comb begin
    scan_req = port_req;
`ifdef DRAM_PORT_ARB_PRIO0_EN
    scan_req[0] = 1'b0;
`endif
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (!found && scan_req[idx[GW-1:0]]) begin
        found = 1'b1;
        win   = idx[GW-1:0];
      end
    end
`ifdef DRAM_PORT_ARB_PRIO0_EN
    if (port_req[0]) begin
      found = 1'b1;
      win   = '0;
    end
`endif
    win_i = 32'(win);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    burst_d = burst_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    bbuf_d  = bbuf_q;
    case (state_q)
      S_IDLE: begin
        if (dram_mem_ready && found) begin
          grant_d = win;
          addr_d  = port_addr[win_i*ADDR_W +: ADDR_W];
          wdata_d = port_wdata[win_i*DATA_W +: DATA_W];
          we_d    = port_write[win];
          // Bursts only for permitted ports, and never for writes.
          burst_d = port_burst[win] & BURST_PORTS[win] & ~port_write[win];
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (dram_data_ready) begin
          if (!we_q) begin
            if (burst_q) bbuf_d  = dram_burst_data;
            else         rdata_d = dram_read_data;
          end
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
`ifdef DRAM_PORT_ARB_PRIO0_EN
        if (grant_q != '0)
`endif
          rr_d = (grant_q == GW'(N_PORTS - 1)) ? '0 : grant_q + 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      burst_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      bbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      bbuf_q  <= bbuf_d;
    end
  end

  always_comb begin
    port_done = '0;
    if (state_q == S_DONE) port_done[grant_q] = 1'b1;
  end

  assign port_err          = (state_q == S_DONE) && err_q;
  assign rdata             = rdata_q;
  assign burst_buf         = bbuf_q;
  assign grant_id          = grant_q;
  assign busy              = (state_q != S_IDLE);
  assign dram_refresh_data = (state_q == S_ISSUE);
  assign dram_write_en     = we_q;
  assign dram_burst_en     = burst_q;
  assign dram_addr         = addr_q;
  assign dram_data_in      = wdata_q;

endmodule

// File: tb/tb_dram_port_arb.sv
module tb_dram_port_arb;

  localparam int NP = 3;
  localparam int AW = 25;
  localparam int DW = 16;
  localparam int BL = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP-1:0]     port_req = '0;
  logic [NP-1:0]     port_write = '0;
  logic [NP-1:0]     port_burst = '0;
  logic [NP*AW-1:0]  port_addr = '0;
  logic [NP*DW-1:0]  port_wdata = '0;
  logic [NP-1:0]     port_done;
  logic              port_err;
  logic [DW-1:0]     rdata;
  logic [BL*DW-1:0]  burst_buf;
  logic [1:0]        grant_id;
  logic              busy;
  logic              dram_mem_ready = 1'b1;
  logic              dram_data_ready = 1'b0;
  logic [DW-1:0]     dram_read_data = '0;
  logic [BL*DW-1:0]  dram_burst_data = '0;
  logic              dram_refresh_data;
  logic              dram_write_en;
  logic              dram_burst_en;
  logic [AW-1:0]     dram_addr;
  logic [DW-1:0]     dram_data_in;

  int vectors = 0;
  int miscompares = 0;

  dram_port_arb #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .port_req(port_req), .port_write(port_write), .port_burst(port_burst),
    .port_addr(port_addr), .port_wdata(port_wdata),
    .port_done(port_done), .port_err(port_err), .rdata(rdata),
    .burst_buf(burst_buf), .grant_id(grant_id), .busy(busy),
    .dram_mem_ready(dram_mem_ready), .dram_data_ready(dram_data_ready),
    .dram_read_data(dram_read_data), .dram_burst_data(dram_burst_data),
    .dram_refresh_data(dram_refresh_data), .dram_write_en(dram_write_en),
    .dram_burst_en(dram_burst_en), .dram_addr(dram_addr),
    .dram_data_in(dram_data_in)
  );

  always #5 clk = ~clk;

  // Controller model: sees the strobe, answers lat cycles later.
  logic [15:0] mem [16] = '{2: 16'h0049, 5: 16'h7777, 9: 16'h1234, default: 16'h0000};
  int          lat = 3;
  int          cd = 0;
  int          strobe_cnt = 0;
  logic        pend = 1'b0;
  logic        p_we = 1'b0;
  logic [24:0] p_addr = '0;
  logic [15:0] p_wd = '0;

  always @(negedge clk) begin
    dram_data_ready = 1'b0;
    if (dram_refresh_data) begin
      strobe_cnt++;
      pend   = 1'b1;
      cd     = lat;
      p_we   = dram_write_en;
      p_addr = dram_addr;
      p_wd   = dram_data_in;
    end else if (pend) begin
      cd--;
      if (cd == 0) begin
        pend = 1'b0;
        dram_data_ready = 1'b1;
        if (p_we) mem[p_addr[3:0]] = p_wd;
        else      dram_read_data = mem[p_addr[3:0]];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (busy !== 1'b0 || port_done !== 3'b000 || port_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status: busy=%b done=%b err=%b expected 0/000/0", busy, port_done, port_err);
    end
    vectors++;
    if (grant_id !== 2'd0 || dram_refresh_data !== 1'b0 || dram_addr !== '0 || rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_fields: gid=%0d strobe=%b addr=%h rdata=%h expected all 0",
               grant_id, dram_refresh_data, dram_addr, rdata);
    end
  endtask

  task automatic test_single_read();
    int n;
    port_addr[1*AW +: AW] = 25'h000002;
    port_write = 3'b000;
    port_req = 3'b010;
    tick();
    n = 1;
    vectors++;
    if (dram_refresh_data !== 1'b1 || dram_addr !== 25'h2 || grant_id !== 2'd1) begin
      miscompares++;
      $display("FAIL read_strobe: strobe=%b addr=%h gid=%0d expected 1/2/1", dram_refresh_data, dram_addr, grant_id);
    end
    while (port_done === 3'b000 && n < 100) begin tick(); n++; end
    vectors++;
    if (n !== 5) begin
      miscompares++;
      $display("FAIL read_latency: done after %0d cycles expected 5", n);
    end
    vectors++;
    if (port_done !== 3'b010 || port_err !== 1'b0 || rdata !== 16'h0049) begin
      miscompares++;
      $display("FAIL read_done: done=%b err=%b rdata=%h expected 010/0/0049", port_done, port_err, rdata);
    end
    vectors++;
    if (strobe_cnt !== 1) begin
      miscompares++;
      $display("FAIL read_strobe_count: %0d expected 1", strobe_cnt);
    end
    port_req = 3'b000;
    tick();
    vectors++;
    if (busy !== 1'b0 || port_done !== 3'b000) begin
      miscompares++;
      $display("FAIL read_idle: busy=%b done=%b expected 0/000", busy, port_done);
    end
  endtask

  task automatic test_write();
    int n;
    port_addr[1*AW +: AW] = 25'h0;
    port_wdata[1*DW +: DW] = 16'hABAB;
    port_write = 3'b010;
    port_req = 3'b010;
    tick();
    n = 1;
    vectors++;
    if (dram_refresh_data !== 1'b1 || dram_write_en !== 1'b1 || dram_data_in !== 16'hABAB || dram_addr !== '0) begin
      miscompares++;
      $display("FAIL write_cmd: strobe=%b we=%b din=%h addr=%h expected 1/1/abab/0",
               dram_refresh_data, dram_write_en, dram_data_in, dram_addr);
    end
    while (port_done === 3'b000 && n < 100) begin tick(); n++; end
    vectors++;
    if (port_done !== 3'b010 || port_err !== 1'b0) begin
      miscompares++;
      $display("FAIL write_done: done=%b err=%b expected 010/0", port_done, port_err);
    end
    vectors++;
    if (mem[0] !== 16'hABAB || rdata !== 16'h0049) begin
      miscompares++;
      $display("FAIL write_effect: mem0=%h rdata=%h expected abab/0049", mem[0], rdata);
    end
    port_req = 3'b000;
    port_write = 3'b000;
    tick();
  endtask

  task automatic test_fairness();
    int order[$];
    int exp_order[6];
    int n;
`ifdef DRAM_PORT_ARB_PRIO0_EN
    exp_order = '{0, 0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 0, 1, 2};
`endif
    do_reset();
    port_write = 3'b000;
    port_req = 3'b111;
    n = 0;
    while (order.size() < 6 && n < 200) begin
      tick();
      n++;
      if (port_done !== 3'b000)
        for (int i = 0; i < NP; i++) if (port_done[i]) order.push_back(i);
    end
    port_req = 3'b000;
    tick();
    vectors++;
    if (order.size() !== 6) begin
      miscompares++;
      $display("FAIL fair_count: %0d grants expected 6", order.size());
    end
    for (int i = 0; i < 6 && i < order.size(); i++) begin
      vectors++;
      if (order[i] !== exp_order[i]) begin
        miscompares++;
        $display("FAIL fair_order[%0d]: port %0d expected %0d", i, order[i], exp_order[i]);
      end
    end
  endtask

  task automatic test_burst();
    int n;
    logic [15:0] exp_w;
    logic [3:0]  k4;
    logic [BL*DW-1:0] saved;
    for (int k = 0; k < BL; k++) begin
      k4 = k[3:0];
      dram_burst_data[k*DW +: DW] = {4'h0, k4, k4, k4};
    end
    port_addr[2*AW +: AW] = {6'h1, 9'd7, 10'd32};
    port_burst = 3'b100;
    port_write = 3'b000;
    port_req = 3'b100;
    tick();
    n = 1;
    vectors++;
    if (dram_burst_en !== 1'b1 || dram_addr !== {6'h1, 9'd7, 10'd32} || grant_id !== 2'd2) begin
      miscompares++;
      $display("FAIL burst_cmd: ben=%b addr=%h gid=%0d expected 1/%h/2", dram_burst_en, dram_addr, grant_id,
               {6'h1, 9'd7, 10'd32});
    end
    while (port_done === 3'b000 && n < 100) begin tick(); n++; end
    vectors++;
    if (port_done !== 3'b100 || port_err !== 1'b0) begin
      miscompares++;
      $display("FAIL burst_done: done=%b err=%b expected 100/0", port_done, port_err);
    end
    for (int k = 0; k < BL; k++) begin
      k4 = k[3:0];
      exp_w = {4'h0, k4, k4, k4};
      vectors++;
      if (burst_buf[k*DW +: DW] !== exp_w) begin
        miscompares++;
        $display("FAIL burst_word[%0d]: %h expected %h", k, burst_buf[k*DW +: DW], exp_w);
      end
    end
    saved = burst_buf;
    port_req = 3'b000;
    port_burst = 3'b000;
    tick();
    // port 0 may not burst: becomes a single read of mem[9]
    port_addr[0*AW +: AW] = 25'h9;
    port_burst = 3'b001;
    port_req = 3'b001;
    tick();
    n = 1;
    vectors++;
    if (dram_refresh_data !== 1'b1 || dram_burst_en !== 1'b0 || grant_id !== 2'd0) begin
      miscompares++;
      $display("FAIL p0_burst_cmd: strobe=%b ben=%b gid=%0d expected 1/0/0", dram_refresh_data, dram_burst_en, grant_id);
    end
    while (port_done === 3'b000 && n < 100) begin tick(); n++; end
    vectors++;
    if (port_done !== 3'b001 || rdata !== 16'h1234 || burst_buf !== saved) begin
      miscompares++;
      $display("FAIL p0_single: done=%b rdata=%h bufkept=%b expected 001/1234/1", port_done, rdata, burst_buf === saved);
    end
    port_req = 3'b000;
    port_burst = 3'b000;
    tick();
    // burst flag on a write is ignored
    port_addr[2*AW +: AW] = 25'h3;
    port_wdata[2*DW +: DW] = 16'h5A5A;
    port_write = 3'b100;
    port_burst = 3'b100;
    port_req = 3'b100;
    tick();
    n = 1;
    vectors++;
    if (dram_burst_en !== 1'b0 || dram_write_en !== 1'b1) begin
      miscompares++;
      $display("FAIL burst_write_cmd: ben=%b we=%b expected 0/1", dram_burst_en, dram_write_en);
    end
    while (port_done === 3'b000 && n < 100) begin tick(); n++; end
    vectors++;
    if (port_done !== 3'b100 || mem[3] !== 16'h5A5A || rdata !== 16'h1234) begin
      miscompares++;
      $display("FAIL burst_write_done: done=%b mem3=%h rdata=%h expected 100/5a5a/1234", port_done, mem[3], rdata);
    end
    port_req = 3'b000;
    port_burst = 3'b000;
    port_write = 3'b000;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    int late_done = 0;
    lat = 25;
    port_addr[1*AW +: AW] = 25'h5;
    port_req = 3'b010;
    tick();
    n = 1;
    while (port_done === 3'b000 && n < 100) begin tick(); n++; end
    vectors++;
    if (n !== 18) begin
      miscompares++;
      $display("FAIL timeout_latency: done after %0d cycles expected 18", n);
    end
    vectors++;
    if (port_done !== 3'b010 || port_err !== 1'b1 || rdata !== 16'h1234) begin
      miscompares++;
      $display("FAIL timeout_done: done=%b err=%b rdata=%h expected 010/1/1234", port_done, port_err, rdata);
    end
    port_req = 3'b000;
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_idle: busy=%b expected 0", busy);
    end
    // late controller response lands around cycle 26 and must be ignored
    for (int i = 0; i < 14; i++) begin
      tick();
      if (port_done !== 3'b000 || busy !== 1'b0) late_done++;
    end
    vectors++;
    if (late_done !== 0 || rdata !== 16'h1234 || pend !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_late: activity=%0d rdata=%h pend=%b expected 0/1234/0", late_done, rdata, pend);
    end
    lat = 3;
  endtask

  task automatic test_mid_reset();
    int spurious = 0;
    lat = 10;
    port_addr[1*AW +: AW] = 25'h2;
    port_req = 3'b010;
    tick();
    tick();
    tick();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_busy: busy=%b expected 1", busy);
    end
    rst = 1'b1;
    port_req = 3'b000;
    tick();
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0 || port_done !== 3'b000) begin
      miscompares++;
      $display("FAIL midrst_abort: busy=%b done=%b expected 0/000", busy, port_done);
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (port_done !== 3'b000 || busy !== 1'b0) spurious++;
    end
    vectors++;
    if (spurious !== 0) begin
      miscompares++;
      $display("FAIL midrst_quiet: %0d active cycles expected 0", spurious);
    end
    lat = 3;
  endtask

  task automatic test_stall();
    int n;
    int s0;
    int bad = 0;
    dram_mem_ready = 1'b0;
    port_req = 3'b100;
    s0 = strobe_cnt;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy !== 1'b0 || dram_refresh_data !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0 || strobe_cnt !== s0) begin
      miscompares++;
      $display("FAIL stall_hold: active=%0d strobes=%0d expected 0/%0d", bad, strobe_cnt, s0);
    end
    dram_mem_ready = 1'b1;
    tick();
    n = 1;
    vectors++;
    if (dram_refresh_data !== 1'b1 || grant_id !== 2'd2) begin
      miscompares++;
      $display("FAIL stall_release: strobe=%b gid=%0d expected 1/2", dram_refresh_data, grant_id);
    end
    while (port_done === 3'b000 && n < 100) begin tick(); n++; end
    vectors++;
    if (port_done !== 3'b100 || port_err !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_done: done=%b err=%b expected 100/0", port_done, port_err);
    end
    port_req = 3'b000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_fairness();
    test_burst();
    test_timeout();
    test_mid_reset();
    test_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dram_port_arb.md
Name: dram_port_arb

Overview:
- Parametrised N-port SDRAM access arbiter; next generation of the fixed CPU-instr / CPU-data / VGA memory map front end.
- Sits between any number of requesters (CPU fetch, CPU data, VGA line fetch, DMA) and the single sdram_ctl command interface.
- Round-robin grant, per-port completion/error pulses, configurable burst length and per-port burst permission, and a timeout watchdog on stalled controller transactions.

Parameters:
- N_PORTS, 3, number of requester ports (2..8).
- ADDR_W, 25, DRAM word address width.
- DATA_W, 16, data word width.
- BURST_LEN, 32, words returned per burst read.
- BURST_PORTS, 3'b100, bit i set = port i may issue bursts.
- TIMEOUT_CYCLES, 1024, maximum cycles in WAIT before forced abort.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- port_req  in  N_PORTS  per-port request, held until that port's done pulse.
- port_write  in  N_PORTS  1 = write, 0 = read.
- port_burst  in  N_PORTS  1 = burst read (ignored unless BURST_PORTS bit is set).
- port_addr  in  N_PORTS*ADDR_W  flattened addresses; port i at [i*ADDR_W +: ADDR_W].
- port_wdata  in  N_PORTS*DATA_W  flattened write data.
- port_done  out  N_PORTS  one-hot completion pulse, 1 cycle.
- port_err  out  1  valid with port_done; 1 = aborted by timeout.
- rdata  out  DATA_W  single-read data, valid from the port_done cycle until the next grant.
- burst_buf  out  BURST_LEN*DATA_W  burst data, same validity as rdata.
- grant_id  out  $clog2(N_PORTS)  index of the port currently being served.
- busy  out  1  high in any state other than IDLE.
- dram_mem_ready  in  1  controller idle and able to accept a command.
- dram_data_ready  in  1  controller completion pulse.
- dram_read_data  in  DATA_W  controller single-read data.
- dram_burst_data  in  BURST_LEN*DATA_W  controller burst buffer.
- dram_refresh_data  out  1  1-cycle command strobe.
- dram_write_en  out  1  write command.
- dram_burst_en  out  1  burst command.
- dram_addr  out  ADDR_W  command address.
- dram_data_in  out  DATA_W  write data.

Behaviour:
- Reset: state IDLE; all outputs 0; round-robin pointer 0; timeout counter 0. A reset mid-transaction aborts with no done pulse; the requester must re-request.
- IDLE:
  - Grant only when dram_mem_ready=1 and port_req is nonzero.
  - Winner is the first requesting port scanning from rr_ptr upward, modulo N_PORTS.
  - Latch the winner's address, write data, write flag, and effective burst (port_burst & BURST_PORTS & ~write); set grant_id; go to ISSUE.
- ISSUE (1 cycle): dram_refresh_data=1 with latched command fields; go to WAIT.
- WAIT:
  - Command fields are held stable and dram_refresh_data=0.
  - On dram_data_ready: for a read, capture dram_read_data into rdata, or dram_burst_data into burst_buf for a burst; for a write, rdata is unchanged. Go to DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 without dram_data_ready, go to DONE with the error flag set.
- DONE (1 cycle):
  - port_done[grant_id]=1; port_err=error flag.
  - rr_ptr = grant_id+1, wrapping N_PORTS-1 to 0.
  - Go to IDLE.
- Latency: request seen in IDLE at cycle 0 → strobe at cycle 1 → done one cycle after dram_data_ready.
- Requesters drop or renew req on the edge where they see done. A req still high in the following IDLE cycle is a new transaction.
- Requests arriving while busy wait; no queueing beyond the req level.
- dram_data_ready outside WAIT is ignored.
- A write with port_burst=1 is executed as a single write.

Optional Feature:
- Macro: DRAM_PORT_ARB_PRIO0_EN.
- Defined: port 0 has strict priority. Any port_req[0] in IDLE wins regardless of rr_ptr. The remaining ports round-robin among themselves, and rr_ptr is not updated on port 0 grants.
- Undefined: pure round robin as above.

Test Plan:
- Single read: port 1 read addr 0x000002, controller returns 0x0049 three cycles after the strobe → one strobe, dram_addr=2, port_done=3'b010 one cycle after data_ready, rdata=0x0049, port_err=0.
- Write: port 1 writes 0xABAB to addr 0 → dram_write_en=1, dram_data_in=0xABAB, model mem[0]=0xABAB, rdata unchanged.
- Fairness: all three ports hold req continuously for 6 transactions → grant order 0,1,2,0,1,2; with DRAM_PORT_ARB_PRIO0_EN → 0,0,0,… (port 0 starves others while held).
- Burst: port 2 burst read at {6'h1,9'd7,10'd32}, model values 0x000,0x111,…,0xFFF,… → dram_burst_en=1, burst_buf word k = {3{k[3:0]}}. Port 0 requesting a burst gets a single read (dram_burst_en=0).
- Timeout: TIMEOUT_CYCLES=16, controller never asserts data_ready → port_done on the 18th cycle after grant with port_err=1, then back in IDLE; a later data_ready is ignored.
- Mid-op reset and stall: rst during WAIT → busy=0 next cycle, no done pulse. With dram_mem_ready=0 and req high → no strobe until ready rises.
